// File: rtl/ysyx_040750_mem_access_stage.sv
// ysyx_040750 MEM stage: issues data-memory loads/stores over a valid/ready bus
// and hands results to MEM_WB through the valid/allowin handshake.
module ysyx_040750_mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_valid,
    output logic        O_allowin,
    output logic        O_valid,
    input  logic        I_MEM_WB_allowin,
    input  logic [31:0] I_pc,
    input  logic [63:0] I_alu_out,
    input  logic [63:0] I_store_data,
    input  logic        I_mem_ren,
    input  logic        I_mem_wen,
    input  logic [7:0]  I_mem_wstrb,
    input  logic [8:0]  I_mem_rstrb,
    input  logic        I_reg_wen,
    input  logic [4:0]  I_rd_addr,
    input  logic [1:0]  I_regin_sel,
    output logic        O_dmem_req_valid,
    input  logic        I_dmem_req_ready,
    output logic [31:0] O_dmem_addr,
    output logic        O_dmem_wen,
    output logic [63:0] O_dmem_wdata,
    output logic [7:0]  O_dmem_wstrb,
    input  logic        I_dmem_resp_valid,
    input  logic [63:0] I_dmem_rdata,
    output logic [31:0] O_pc,
    output logic [63:0] O_alu_out,
    output logic        O_reg_wen,
    output logic [4:0]  O_rd_addr,
    output logic [1:0]  O_regin_sel,
    output logic [8:0]  O_mem_rstrb,
    output logic [2:0]  O_mem_shamt,
    output logic [63:0] O_mem_data,
    output logic        O_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          accept, in_mem, resp_hit, tmo;

    logic [31:0]   pc_q;
    logic [63:0]   alu_q, sdata_q, mem_data_q;
    logic          ren_q, wen_q, reg_wen_q, err_q;
    logic [7:0]    wstrb_q;
    logic [8:0]    rstrb_q;
    logic [4:0]    rd_q;
    logic [1:0]    sel_q;

    assign accept  = I_valid & O_allowin;
    assign in_mem  = I_mem_ren | I_mem_wen;
    assign cnt_inc = cnt_q + 1'b1;

    // A response only counts once the request has been taken.
    assign resp_hit = I_dmem_resp_valid &
                      ((state_q == REQ & I_dmem_req_ready) | state_q == WAIT);
    assign tmo      = state_q == WAIT & ~I_dmem_resp_valid &
                      cnt_inc == CW'(TIMEOUT);

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = in_mem ? REQ : DONE;
            REQ:  if (I_dmem_req_ready)
                      state_d = I_dmem_resp_valid ? DONE : WAIT;
            WAIT: if (I_dmem_resp_valid | tmo) state_d = DONE;
            DONE: if (I_MEM_WB_allowin)
                      state_d = accept ? (in_mem ? REQ : DONE) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        O_valid          = state_q == DONE;
        O_allowin        = state_q == IDLE |
                           (state_q == DONE & I_MEM_WB_allowin);
        O_dmem_req_valid = state_q == REQ;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == REQ & I_dmem_req_ready) begin
            cnt_d = '0;
        end else if (state_q == WAIT & ~I_dmem_resp_valid) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            cnt_q      <= '0;
            pc_q       <= '0;
            alu_q      <= '0;
            sdata_q    <= '0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            wstrb_q    <= '0;
            rstrb_q    <= '0;
            reg_wen_q  <= 1'b0;
            rd_q       <= '0;
            sel_q      <= '0;
            mem_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                pc_q       <= I_pc;
                alu_q      <= I_alu_out;
                sdata_q    <= I_store_data;
                ren_q      <= I_mem_ren;
                wen_q      <= I_mem_wen;
                wstrb_q    <= I_mem_wstrb;
                rstrb_q    <= I_mem_rstrb;
                reg_wen_q  <= I_reg_wen;
                rd_q       <= I_rd_addr;
                sel_q      <= I_regin_sel;
                mem_data_q <= '0;
                err_q      <= 1'b0;
            end else begin
                if (resp_hit & ren_q) mem_data_q <= I_dmem_rdata;
                if (tmo) err_q <= 1'b1;
            end
        end
    end

    // Lane shifting; accesses crossing the doubleword are simply truncated.
    assign O_dmem_addr  = {alu_q[31:3], 3'b000};
    assign O_dmem_wen   = wen_q;
    assign O_dmem_wdata = sdata_q << {alu_q[2:0], 3'b000};
    assign O_dmem_wstrb = wstrb_q << alu_q[2:0];

    assign O_pc        = pc_q;
    assign O_alu_out   = alu_q;
    assign O_reg_wen   = reg_wen_q;
    assign O_rd_addr   = rd_q;
    assign O_regin_sel = sel_q;
    assign O_mem_rstrb = rstrb_q;
    assign O_mem_shamt = alu_q[2:0];
    assign O_mem_data  = mem_data_q;
    assign O_err       = err_q;

endmodule

// File: tb/tb_ysyx_040750_mem_access_stage.sv
// Randomized bench for the MEM stage against a transaction-level model
// with a behavioural data-memory responder.
module tb_ysyx_040750_mem_access_stage;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        I_valid = 0, I_MEM_WB_allowin = 0;
    logic [31:0] I_pc = 0;
    logic [63:0] I_alu_out = 0, I_store_data = 0, I_dmem_rdata = 0;
    logic        I_mem_ren = 0, I_mem_wen = 0, I_reg_wen = 0;
    logic [7:0]  I_mem_wstrb = 0;
    logic [8:0]  I_mem_rstrb = 0;
    logic [4:0]  I_rd_addr = 0;
    logic [1:0]  I_regin_sel = 0;
    logic        I_dmem_req_ready = 0, I_dmem_resp_valid = 0;

    logic        O_allowin, O_valid, O_dmem_req_valid, O_dmem_wen;
    logic        O_reg_wen, O_err;
    logic [31:0] O_dmem_addr, O_pc;
    logic [63:0] O_dmem_wdata, O_alu_out, O_mem_data;
    logic [7:0]  O_dmem_wstrb;
    logic [8:0]  O_mem_rstrb;
    logic [4:0]  O_rd_addr;
    logic [1:0]  O_regin_sel;
    logic [2:0]  O_mem_shamt;

    ysyx_040750_mem_access_stage #(.TIMEOUT(TO)) dut (
        .I_sys_clk(clk), .I_rst(rst),
        .I_valid(I_valid), .O_allowin(O_allowin), .O_valid(O_valid),
        .I_MEM_WB_allowin(I_MEM_WB_allowin),
        .I_pc(I_pc), .I_alu_out(I_alu_out), .I_store_data(I_store_data),
        .I_mem_ren(I_mem_ren), .I_mem_wen(I_mem_wen),
        .I_mem_wstrb(I_mem_wstrb), .I_mem_rstrb(I_mem_rstrb),
        .I_reg_wen(I_reg_wen), .I_rd_addr(I_rd_addr),
        .I_regin_sel(I_regin_sel),
        .O_dmem_req_valid(O_dmem_req_valid),
        .I_dmem_req_ready(I_dmem_req_ready),
        .O_dmem_addr(O_dmem_addr), .O_dmem_wen(O_dmem_wen),
        .O_dmem_wdata(O_dmem_wdata), .O_dmem_wstrb(O_dmem_wstrb),
        .I_dmem_resp_valid(I_dmem_resp_valid), .I_dmem_rdata(I_dmem_rdata),
        .O_pc(O_pc), .O_alu_out(O_alu_out), .O_reg_wen(O_reg_wen),
        .O_rd_addr(O_rd_addr), .O_regin_sel(O_regin_sel),
        .O_mem_rstrb(O_mem_rstrb), .O_mem_shamt(O_mem_shamt),
        .O_mem_data(O_mem_data), .O_err(O_err)
    );

    // dly: 0 = response with the request, n = n-th cycle after it,
    // TO+1 = memory never answers.
    typedef struct {
        logic [31:0] pc;
        logic [63:0] alu, sd, rdata;
        logic        ren, wen, rw;
        logic [7:0]  ws;
        logic [8:0]  rs;
        logic [4:0]  rd;
        logic [1:0]  sel;
        int          dly;
    } ins_t;

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ins_t gen(input int k);
        ins_t t;
        int   ty;
        t.pc    = $urandom;
        t.alu   = {$urandom, $urandom};
        t.sd    = {$urandom, $urandom};
        t.rdata = {$urandom, $urandom};
        t.ws    = 8'($urandom);
        t.rs    = 9'($urandom);
        t.rw    = 1'($urandom);
        t.rd    = 5'($urandom);
        t.sel   = 2'($urandom);
        t.dly   = $urandom_range(0, TO + 1);
        ty      = $urandom_range(0, 2);
        if (k < 4) begin
            ty    = 0;
            t.alu = 64'(k + 1);
        end else if (k == 4) begin
            ty = 2; t.alu = 64'h1006; t.ws = 8'h03;
            t.sd = 64'hABCD; t.dly = 1;
        end else if (k == 5) begin
            ty = 1; t.alu = 64'h8000_0005;
            t.rdata = 64'h1122_3344_5566_7788; t.dly = 3;
        end else if (k == 6) begin
            ty = 1; t.dly = TO + 1;
        end
        t.ren = ty == 1;
        t.wen = ty == 2;
        return t;
    endfunction

    // Model phase: 0 empty, 1 request pending, 2 waiting, 3 result held.
    int   ph = 0, wc = 0, k = 0;
    ins_t cur, pend;
    bit   pend_v = 0;
    logic [63:0] exp_data;
    logic        exp_err;

    task automatic step(input bit allow_new);
        bit wb, acc, mem;
        @(negedge clk);
        chk("o_valid", O_valid, 64'(ph == 3));
        chk("req_valid", O_dmem_req_valid, 64'(ph == 1));
        if (ph == 1) begin
            chk("dmem_addr", O_dmem_addr, {cur.alu[31:3], 3'b000});
            chk("dmem_wen", O_dmem_wen, cur.wen);
            chk("dmem_wdata", O_dmem_wdata,
                cur.sd * (64'd1 << (8 * cur.alu[2:0])));
            chk("dmem_wstrb", O_dmem_wstrb,
                (64'(cur.ws) << cur.alu[2:0]) & 64'hff);
        end
        if (ph == 3) begin
            mem      = cur.ren | cur.wen;
            exp_err  = mem && cur.dly > TO;
            exp_data = (cur.ren && cur.dly <= TO) ? cur.rdata : 64'd0;
            chk("o_pc", O_pc, cur.pc);
            chk("o_alu", O_alu_out, cur.alu);
            chk("o_pass", {O_reg_wen, O_rd_addr, O_regin_sel, O_mem_rstrb},
                {cur.rw, cur.rd, cur.sel, cur.rs});
            chk("o_shamt", O_mem_shamt, cur.alu[2:0]);
            chk("o_mem_data", O_mem_data, exp_data);
            chk("o_err", O_err, exp_err);
        end
        wb = (k <= 4) || ($urandom_range(0, 3) != 0);
        if (!pend_v && allow_new && (k < 4 || $urandom_range(0, 2) != 0)) begin
            pend   = gen(k);
            k++;
            pend_v = 1;
        end
        I_MEM_WB_allowin = wb;
        I_valid      = pend_v;
        I_pc         = pend.pc;
        I_alu_out    = pend.alu;
        I_store_data = pend.sd;
        I_mem_ren    = pend.ren;
        I_mem_wen    = pend.wen;
        I_mem_wstrb  = pend.ws;
        I_mem_rstrb  = pend.rs;
        I_reg_wen    = pend.rw;
        I_rd_addr    = pend.rd;
        I_regin_sel  = pend.sel;
        I_dmem_req_ready = 1'($urandom);
        if (ph == 1 && I_dmem_req_ready)
            I_dmem_resp_valid = cur.dly == 0;
        else if (ph == 2)
            I_dmem_resp_valid = (wc + 1) == cur.dly;
        else
            I_dmem_resp_valid = $urandom_range(0, 4) == 0;
        I_dmem_rdata = (ph == 1 || ph == 2) ? cur.rdata : {$urandom, $urandom};
        #1;
        chk("allowin", O_allowin, 64'(ph == 0 || (ph == 3 && wb)));
        acc = I_valid && (ph == 0 || (ph == 3 && wb));
        case (ph)
            1: if (I_dmem_req_ready) begin
                   if (cur.dly == 0) ph = 3;
                   else begin ph = 2; wc = 0; end
               end
            2: if (I_dmem_resp_valid) ph = 3;
               else begin
                   wc++;
                   if (wc == TO) ph = 3;
               end
            3: if (wb) ph = 0;
            default: ;
        endcase
        if (acc) begin
            cur    = pend;
            pend_v = 0;
            ph     = (cur.ren | cur.wen) ? 1 : 3;
        end
    endtask

    initial begin
        #12;
        chk("rst_valid", O_valid, 0);
        chk("rst_allowin", O_allowin, 1);
        chk("rst_req", O_dmem_req_valid, 0);
        chk("rst_outs", {O_pc, O_alu_out[31:0]}, 0);
        chk("rst_data", {O_mem_data, O_err}, 0);
        rst = 0;
        repeat (1500) step(1);
        repeat (25) step(0);
        chk("drained", 64'(ph), 0);

        // Abandon an outstanding load by an asynchronous reset.
        @(negedge clk);
        I_valid = 1; I_mem_ren = 1; I_mem_wen = 0; I_MEM_WB_allowin = 1;
        I_dmem_req_ready = 0; I_dmem_resp_valid = 0;
        @(negedge clk);
        chk("rst_t_req", O_dmem_req_valid, 1);
        I_valid = 0; I_dmem_req_ready = 1;
        @(negedge clk);
        I_dmem_req_ready = 0;
        #2 rst = 1;
        #1;
        chk("arst_req", O_dmem_req_valid, 0);
        chk("arst_allowin", O_allowin, 1);
        #1 rst = 0;
        @(negedge clk);
        @(negedge clk);
        I_dmem_resp_valid = 1; I_dmem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        I_dmem_resp_valid = 0;
        chk("late_resp_valid", O_valid, 0);
        chk("late_resp_data", O_mem_data, 0);
        @(negedge clk);
        chk("late_resp_valid2", O_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
